// File: rtl/bel_fft_avl_pipe_sif.sv
// Pipelined Avalon-MM slave to internal register-bus bridge for bel_fft.
// Tracks up to MAX_PEND in-order outstanding commands in a tag FIFO, with ack timeout.
module bel_fft_avl_pipe_sif #(
  parameter int AWIDTH   = 8,
  parameter int DWIDTH   = 32,
  parameter int BCNT     = DWIDTH / 8,
  parameter int MAX_PEND = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] address,
  input  logic [DWIDTH-1:0] writedata,
  input  logic              read,
  input  logic              write,
  input  logic [BCNT-1:0]   byteenable,
  output logic              waitrequest,
  output logic [DWIDTH-1:0] readdata,
  output logic              readdatavalid,
  output logic [1:0]        response,
  output logic [AWIDTH-1:0] adr_o,
  output logic [DWIDTH-1:0] dat_o,
  output logic [BCNT-1:0]   bsel_o,
  output logic              rd_o,
  output logic              wr_o,
  input  logic [DWIDTH-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  output logic              err_flag_o,
  input  logic              err_clr_i
);

  localparam int PW = $clog2(MAX_PEND);
  localparam int OW = PW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [OW-1:0] OCC_FULL = OW'(MAX_PEND);

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [OW-1:0]       occ;
  logic [OW-1:0]       occ_nxt;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [MAX_PEND-1:0] tag_mem;
  logic [TW-1:0]       tmo_cnt;

  logic acc_p0;
  logic pend_p0;
  logic cpl_p0;
  logic tmo_p0;
  logic pop_p0;
  logic pop_rd_p0;
  logic pop_err_p0;
  logic err_set_p0;

  // Stage p0: accept/completion decode, all from registered state plus inputs
  always_comb begin
    acc_p0     = (read | write) & ~waitrequest;
    pend_p0    = (occ != '0);
    cpl_p0     = (ack_i | err_i) & pend_p0;
    tmo_p0     = TMO_EN & pend_p0 & ~(ack_i | err_i) & (tmo_cnt == TMO_LAST);
    pop_p0     = cpl_p0 | tmo_p0;
    pop_err_p0 = err_i | tmo_p0;
    pop_rd_p0  = pop_p0 & tag_mem[rd_ptr];
    // Stray completions with nothing outstanding are dropped but flagged.
    err_set_p0 = err_i | tmo_p0 | (ack_i & ~pend_p0);
  end

  always_comb begin
    occ_nxt = occ;
    unique case ({acc_p0, pop_p0})
      2'b10:   occ_nxt = occ + OW'(1);
      2'b01:   occ_nxt = occ - OW'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Tag storage holds no control state, so it is left unreset.
  always_ff @(posedge clk_i) begin
    if (acc_p0) begin
      tag_mem[wr_ptr] <= read;
    end
  end

  // Stage p1: FIFO bookkeeping, issue strobes and read-return registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tmo_cnt       <= '0;
      waitrequest   <= 1'b0;
      rd_o          <= 1'b0;
      wr_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
      bsel_o        <= '0;
      readdatavalid <= 1'b0;
      readdata      <= '0;
      response      <= RESP_OKAY;
      err_flag_o    <= 1'b0;
    end else begin
      occ         <= occ_nxt;
      waitrequest <= (occ_nxt == OCC_FULL);

      if (acc_p0) begin
        wr_ptr <= wr_ptr + PW'(1);
        adr_o  <= address;
        dat_o  <= writedata;
        bsel_o <= byteenable;
      end
      if (pop_p0) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      // A read wins when both read and write are asserted together.
      rd_o <= acc_p0 & read;
      wr_o <= acc_p0 & ~read;

      if (!pend_p0 || pop_p0) begin
        tmo_cnt <= '0;
      end else if (TMO_EN) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      readdatavalid <= pop_rd_p0;
      response      <= (pop_rd_p0 & pop_err_p0) ? RESP_SLVERR : RESP_OKAY;
      if (pop_rd_p0) begin
        readdata <= dat_i;
      end

      if (err_set_p0) begin
        err_flag_o <= 1'b1;
      end else if (err_clr_i) begin
        err_flag_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bel_fft_avl_pipe_sif.sv
// Scoreboard bench for bel_fft_avl_pipe_sif: expected read returns are queued
// when a completion is driven and checked whenever readdatavalid pulses.
module tb_bel_fft_avl_pipe_sif;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int BC  = DW / 8;
  localparam int MP  = 4;
  localparam int TMO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic          read;
  logic          write;
  logic [BC-1:0] byteenable;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;
  logic [1:0]    response;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [BC-1:0] bsel_o;
  logic          rd_o;
  logic          wr_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;
  logic          err_i;
  logic          err_flag_o;
  logic          err_clr_i;

  bel_fft_avl_pipe_sif #(
    .AWIDTH(AW), .DWIDTH(DW), .BCNT(BC), .MAX_PEND(MP), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .address(address), .writedata(writedata), .read(read), .write(write),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .response(response),
    .adr_o(adr_o), .dat_o(dat_o), .bsel_o(bsel_o), .rd_o(rd_o), .wr_o(wr_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i),
    .err_flag_o(err_flag_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    bit            chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdv_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_rd(input logic [DW-1:0] d, input logic [1:0] r, input bit cd);
    exp_t e;
    e.data = d;
    e.resp = r;
    e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  // Issue one command, wait the mandatory cycle, then complete it.
  task automatic do_txn(input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [BC-1:0] be, input logic [DW-1:0] rdat, input bit use_err);
    address = a; writedata = wd; byteenable = be;
    read = is_rd; write = ~is_rd;
    step();
    read = 1'b0; write = 1'b0;
    if (!is_rd) begin
      check_eq("wr_strobe", wr_o, 1'b1);
      check_eq("wr_dat", dat_o, wd);
      check_eq("wr_bsel", bsel_o, be);
    end
    step();
    dat_i = rdat; ack_i = ~use_err; err_i = use_err;
    if (is_rd) expect_rd(rdat, use_err ? 2'b10 : 2'b00, !use_err);
    step();
    ack_i = 1'b0; err_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (rst_i && readdatavalid) begin
      rdv_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("rdv_unexpected", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_resp", response, mon_e.resp);
        if (mon_e.chk_data) check_eq("sb_rdata", readdata, mon_e.data);
      end
    end
  end

  initial begin
    rst_i = 1'b0; address = '0; writedata = '0; read = 1'b0; write = 1'b0;
    byteenable = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) step();
    check_eq("rst_ctrl", {waitrequest, readdatavalid, rd_o, wr_o, err_flag_o, response}, '0);
    check_eq("rst_adr", adr_o, '0);
    check_eq("rst_dat", dat_o, '0);
    check_eq("rst_bsel", bsel_o, '0);
    check_eq("rst_rdata", readdata, '0);
    rst_i = 1'b1;
    step();

    // single read, ack one cycle after rd_o
    address = 8'h10; read = 1'b1;
    step();
    read = 1'b0;
    check_eq("t1_rd_o", rd_o, 1'b1);
    check_eq("t1_wr_o", wr_o, 1'b0);
    check_eq("t1_adr", adr_o, 8'h10);
    step();
    check_eq("t1_rd_once", rd_o, 1'b0);
    dat_i = 32'hCAFEF00D; ack_i = 1'b1;
    expect_rd(32'hCAFEF00D, 2'b00, 1'b1);
    step();
    ack_i = 1'b0;
    check_eq("t1_rdv_lat3", readdatavalid, 1'b1);
    step();
    check_eq("t1_rdv_pulse", readdatavalid, 1'b0);

    // four back-to-back reads fill the FIFO
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_wait_low", waitrequest, 1'b0);
      address = 8'(8'h20 + i); read = 1'b1;
      step();
    end
    read = 1'b0;
    check_eq("t2_wait_full", waitrequest, 1'b1);
    step();
    check_eq("t2_wait_still", waitrequest, 1'b1);
    dat_i = 32'hA0000000; ack_i = 1'b1;
    expect_rd(32'hA0000000, 2'b00, 1'b1);
    step();
    check_eq("t2_wait_drop", waitrequest, 1'b0);
    for (int i = 1; i < 4; i++) begin
      dat_i = 32'hA0000000 + 32'(i);
      expect_rd(32'hA0000000 + 32'(i), 2'b00, 1'b1);
      step();
    end
    ack_i = 1'b0;
    step();
    step();
    check_eq("t2_wait_empty", waitrequest, 1'b0);

    // write/read/write/read, second read errored
    check_eq("t3_flag_init", err_flag_o, 1'b0);
    rdv_cnt = 0;
    do_txn(1'b0, 8'h30, 32'h11223344, 4'h3, 32'h0, 1'b0);
    do_txn(1'b1, 8'h31, 32'h0, 4'hF, 32'h55667788, 1'b0);
    do_txn(1'b0, 8'h32, 32'h99AABBCC, 4'hC, 32'h0, 1'b0);
    check_eq("t3_flag_pre", err_flag_o, 1'b0);
    do_txn(1'b1, 8'h33, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1);
    step();
    step();
    check_eq("t3_rdv_count", rdv_cnt, 2);
    check_eq("t3_flag_set", err_flag_o, 1'b1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    check_eq("t3_flag_clr", err_flag_o, 1'b0);

    // unacked read times out 8 cycles after rd_o
    expect_rd(32'h0, 2'b10, 1'b0);
    address = 8'h40; read = 1'b1;
    step();
    read = 1'b0;
    check_eq("t4_rd_o", rd_o, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step();
      check_eq("t4_no_rdv_early", readdatavalid, 1'b0);
    end
    step();
    check_eq("t4_rdv_tmo", readdatavalid, 1'b1);
    check_eq("t4_flag", err_flag_o, 1'b1);
    step();
    check_eq("t4_rdv_once", readdatavalid, 1'b0);
    check_eq("t4_wait", waitrequest, 1'b0);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;

    // accept and ack in the same cycle at occ=3, then read&write together
    for (int i = 0; i < 3; i++) begin
      address = 8'(8'h50 + i); read = 1'b1;
      step();
    end
    address = 8'h53; read = 1'b1; dat_i = 32'hB0000000; ack_i = 1'b1;
    expect_rd(32'hB0000000, 2'b00, 1'b1);
    step();
    read = 1'b0; ack_i = 1'b0;
    check_eq("t5_occ3_wait", waitrequest, 1'b0);
    address = 8'h55; read = 1'b1; write = 1'b1;
    step();
    read = 1'b0; write = 1'b0;
    check_eq("t5_rw_rd", rd_o, 1'b1);
    check_eq("t5_rw_wr", wr_o, 1'b0);
    check_eq("t5_rw_adr", adr_o, 8'h55);
    check_eq("t5_full", waitrequest, 1'b1);
    for (int i = 1; i < 5; i++) begin
      dat_i = 32'hB0000000 + 32'(i); ack_i = 1'b1;
      expect_rd(32'hB0000000 + 32'(i), 2'b00, 1'b1);
      step();
    end
    ack_i = 1'b0;
    step();
    step();
    check_eq("t5_flag", err_flag_o, 1'b0);

    // reset with three reads outstanding
    for (int i = 0; i < 3; i++) begin
      address = 8'(8'h60 + i); read = 1'b1;
      step();
    end
    read = 1'b0;
    rst_i = 1'b0;
    #1;
    check_eq("t6_rst_ctrl", {waitrequest, readdatavalid, rd_o, wr_o, err_flag_o, response}, '0);
    check_eq("t6_rst_adr", adr_o, '0);
    check_eq("t6_rst_rdata", readdata, '0);
    step();
    step();
    rst_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("t6_no_stale", readdatavalid, 1'b0);
    end
    address = 8'h70; read = 1'b1;
    step();
    read = 1'b0;
    check_eq("t6_rd_o", rd_o, 1'b1);
    step();
    dat_i = 32'h12345678; ack_i = 1'b1;
    expect_rd(32'h12345678, 2'b00, 1'b1);
    step();
    ack_i = 1'b0;
    check_eq("t6_rdv", readdatavalid, 1'b1);
    step();
    step();
    check_eq("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
